puf_resp_checker: RTL and testbench
===================================

Name: puf_resp_checker

Overview:
- Consumer side of the 128-bit PUF response interface (puf_out / puf_done) produced by the PUF collection FSM.
- On request, restarts the PUF collector through its active-high reset and waits for puf_done.
- Latches puf_out, computes Hamming distance against an enrolled reference 16 bits per cycle, and reports pass/fail against a threshold.
- Used for device authentication and reliability measurement.

Parameters:
- RESP_W, 128, response width; must equal NSLICE*SLICE_W.
- SLICE_W, 16, bits compared per COMPARE cycle.
- NSLICE, 8, number of COMPARE cycles.
- HD_W, 8, Hamming-distance width; must hold RESP_W.
- TIMEOUT_CYC, 1024, maximum WAIT cycles before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only in IDLE.
- ref_resp  in  RESP_W  enrolled reference response; sampled when start is accepted.
- threshold  in  HD_W  maximum accepted Hamming distance; sampled when start is accepted.
- puf_out  in  RESP_W  response from the PUF collector.
- puf_done  in  1  collector done level; held high while the collector is finished.
- puf_rst  out  1  active-high reset driven to the PUF collector.
- busy  out  1  high in every state except IDLE.
- valid  out  1  one-cycle result strobe.
- hd  out  HD_W  Hamming distance of the last check.
- match  out  1  1 when hd <= threshold and no timeout.
- timeout  out  1  last check aborted because puf_done never arrived.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; puf_rst=1; busy=0; valid=0; hd=0; match=0; timeout=0.
  - Internal response, reference, threshold, accumulator and counters all cleared.
  - Asserting reset mid-operation aborts immediately; no valid pulse is issued.
- States: IDLE, ARM, WAIT, COMPARE, REPORT.
- IDLE:
  - puf_rst=1, which holds the collector in reset.
  - start=1 at edge Es: capture ref_resp and threshold, clear accumulator, go to ARM.
- ARM (1 cycle):
  - puf_rst stays 1, guaranteeing at least two reset edges for the collector.
  - At Es+1: puf_rst<=0, timeout counter<=0, go to WAIT.
- WAIT:
  - puf_rst=0; the counter increments each cycle.
  - puf_done=1 at edge Ed: latch puf_out into the response register, slice index<=0, go to COMPARE.
  - Otherwise, if counter==TIMEOUT_CYC-1: go to REPORT with hd<=all-ones, match<=0, timeout<=1.
  - If puf_done and the timeout limit coincide on the same edge, puf_done wins.
- COMPARE (NSLICE cycles, MSB slice first):
  - Slice k = resp[RESP_W-1-k*SLICE_W -: SLICE_W] XOR ref at the same bits.
  - acc <= acc + popcount(slice k), computed in HD_W-bit unsigned arithmetic with no overflow (max 128).
  - At edge Ed+8 (k=NSLICE-1): hd<=final sum, match<=(final sum <= threshold), timeout<=0, valid<=1, go to REPORT.
  - puf_rst stays 0 throughout COMPARE.
- REPORT:
  - valid=1 for exactly this one cycle.
  - Next edge: valid<=0, puf_rst<=1, go to IDLE.
  - Total latency from puf_done sampled to valid high is 8 edges after Ed.
  - For a timeout, valid is high the cycle after the limit edge.
- Results:
  - hd, match and timeout hold their values until the next valid pulse.
  - They are not cleared on a new start.
- Input handling:
  - start while busy=1 is ignored and never queued.
  - start on the same edge as REPORT→IDLE is also ignored.
  - puf_out changing after Ed has no effect.
  - ref_resp and threshold changes after Es have no effect.
- threshold >= 128 always gives match=1 unless timeout occurred.
- threshold = 0 requires an exact match.

Test Plan:
- Identical inputs: ref_resp=puf_out=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, threshold=0 → hd=0, match=1, timeout=0; valid exactly 8 edges after puf_done is sampled; puf_rst low only during WAIT/COMPARE.
- Distance vs threshold: ref differs from puf_out in bits {127,100,64,31,0} (hd=5).
  - threshold=4 → match=0, hd=5.
  - Rerun with threshold=5 → match=1.
- Full mismatch: ref=~puf_out, threshold=127 → hd=128 (8'h80), match=0; no accumulator overflow.
- Timeout: puf_done tied low, TIMEOUT_CYC=16 → valid 17 cycles after ARM exits; timeout=1, match=0, hd=8'hFF; returns to IDLE with puf_rst=1.
- Start ignored while busy: pulse start during WAIT and during COMPARE with a different ref_resp → single valid pulse; result uses the first ref_resp.
- Async reset mid-COMPARE: drop rst between edges at k=3 → outputs go to reset values immediately with puf_rst=1 and no valid pulse; after release, a fresh start completes normally.

Source files
------------

// File: rtl/puf_resp_checker.sv
// Restarts the PUF collector, latches its 128-bit response and measures the Hamming
// distance to an enrolled reference one slice per cycle, reporting pass/fail or timeout.
module puf_resp_checker #(
  parameter int RESP_W      = 128,
  parameter int SLICE_W     = 16,
  parameter int NSLICE      = 8,
  parameter int HD_W        = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RESP_W-1:0] ref_resp,
  input  logic [HD_W-1:0]   threshold,
  input  logic [RESP_W-1:0] puf_out,
  input  logic              puf_done,
  output logic              puf_rst,
  output logic              busy,
  output logic              valid,
  output logic [HD_W-1:0]   hd,
  output logic              match,
  output logic              timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_COMPARE,
    S_REPORT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RESP_W-1:0] r_resp;
  logic [RESP_W-1:0] r_ref;
  logic [HD_W-1:0]   r_thr;
  logic [HD_W-1:0]   r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [HD_W-1:0]   r_hd;
  logic              r_match;
  logic              r_timeout;
  logic [RESP_W-1:0] w_diff;
  logic [SLICE_W-1:0] w_slice;
  logic [HD_W-1:0]   w_sum;

  function automatic logic [HD_W-1:0] popcount(input logic [SLICE_W-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < SLICE_W; i++) c = c + HD_W'(v[i]);
    return c;
  endfunction

  // Shifting slice k up to the top keeps the MSB-first slice order without a wide mux.
  assign w_diff  = (r_resp ^ r_ref) << (int'(r_idx) * SLICE_W);
  assign w_slice = w_diff[RESP_W-1 -: SLICE_W];
  assign w_sum   = r_acc + popcount(w_slice);

  always_comb begin
    w_next  = r_state;
    puf_rst = 1'b0;
    busy    = 1'b1;
    valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        puf_rst = 1'b1;
        busy    = 1'b0;
        if (start) w_next = S_ARM;
      end
      S_ARM: begin
        puf_rst = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (puf_done)              w_next = S_COMPARE;
        else if (r_cnt == CNT_LAST) w_next = S_REPORT;
      end
      S_COMPARE: begin
        if (r_idx == IDX_LAST) w_next = S_REPORT;
      end
      S_REPORT: begin
        valid  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_resp    <= '0;
      r_ref     <= '0;
      r_thr     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_hd      <= '0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ref <= ref_resp;
            r_thr <= threshold;
            r_acc <= '0;
          end
        end
        S_ARM: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A done seen on the limit edge still wins over the timeout.
          if (puf_done) begin
            r_resp <= puf_out;
            r_idx  <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_hd      <= '1;
            r_match   <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        S_COMPARE: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            r_hd      <= w_sum;
            r_match   <= (w_sum <= r_thr);
            r_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hd      = r_hd;
  assign match   = r_match;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_puf_resp_checker.sv
// Randomised bench for puf_resp_checker: a timeline-based model predicts every output
// each cycle, and directed transactions pin the model with literal expectations.
module tb_puf_resp_checker;

  localparam int TO = 16;
  localparam int NS = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] ref_resp;
  logic [7:0]   threshold;
  logic [127:0] puf_out;
  logic         puf_done;
  logic         puf_rst;
  logic         busy;
  logic         valid;
  logic [7:0]   hd;
  logic         match;
  logic         timeout;

  int n_vec = 0;
  int n_bad = 0;

  puf_resp_checker #(
    .RESP_W(128), .SLICE_W(16), .NSLICE(NS), .HD_W(8), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ref_resp(ref_resp), .threshold(threshold),
    .puf_out(puf_out), .puf_done(puf_done), .puf_rst(puf_rst), .busy(busy),
    .valid(valid), .hd(hd), .match(match), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: each accepted request is a timeline of edge numbers. t_s is the accept edge,
  // the collector is watched from t_s+2, and t_v is the edge after which valid shows.
  int           cyc = 0;
  int           t_s = 0;
  int           t_v = 0;
  bit           act = 0;
  bit           got = 0;
  logic [127:0] m_ref = '0;
  logic [7:0]   m_thr = '0;
  logic [7:0]   e_hd = '0;
  logic [7:0]   p_hd = '0;
  bit           e_m = 0, e_t = 0, p_m = 0, p_t = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      act = 0; got = 0; e_hd = '0; e_m = 0; e_t = 0;
    end else begin
      cyc++;
      if (act) begin
        if (got && cyc == t_v + 1) act = 0;
        else if (!got && cyc >= t_s + 2) begin
          if (puf_done) begin
            got = 1; t_v = cyc + NS;
            p_hd = 8'($countones(puf_out ^ m_ref)); p_m = (p_hd <= m_thr); p_t = 0;
          end else if (cyc == t_s + 1 + TO) begin
            got = 1; t_v = cyc; p_hd = 8'hFF; p_m = 0; p_t = 1;
          end
        end
        if (got && cyc == t_v) begin
          e_hd = p_hd; e_m = p_m; e_t = p_t;
        end
      end else if (start) begin
        act = 1; got = 0; t_s = cyc; m_ref = ref_resp; m_thr = threshold;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", valid, act && got && cyc == t_v);
    chk("busy", busy, act);
    chk("puf_rst", puf_rst, !(act && cyc >= t_s + 1));
    chk("hd", hd, e_hd);
    chk("match", match, e_m);
    chk("timeout", timeout, e_t);
  end

  // Called on a negedge with the DUT idle; returns one negedge after the valid cycle.
  task automatic run_txn(input logic [127:0] rf, input logic [127:0] rs, input logic [7:0] th,
                         input int dly, input bit poke, input bit late,
                         output int lat_s, output int lat_d);
    int done_at;
    bit seen;
    done_at = -1; seen = 0; lat_s = -1; lat_d = -1;
    start = 1; ref_resp = rf; threshold = th; puf_out = rnd128();
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      start = 0;
      ref_resp = rnd128();
      threshold = 8'($urandom);
      if (valid) begin
        seen = 1; lat_s = i;
        if (done_at > 0) lat_d = i - 1 - done_at;
      end else begin
        if (poke && (i % 2 == 1)) start = 1;
        if (done_at > 0) puf_out = rnd128();
        else if (i == dly) begin
          puf_done = 1; puf_out = rs; done_at = i;
        end
      end
    end
    if (!seen) chk("valid_wait", 0, 1);
    start = late; puf_done = 0;
    @(negedge clk);
    start = 0;
    if (late) chk("late_start_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int ls, ld;
    logic [127:0] a, m, r;
    logic [7:0] th;
    int hv;
    rst = 0; start = 0; ref_resp = '0; threshold = '0; puf_out = '0; puf_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_puf_rst", puf_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hd", hd, 0);
    rst = 1;

    a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    run_txn(a, a, 8'd0, 3, 0, 0, ls, ld);
    chk("ident_hd", hd, 8'd0);
    chk("ident_match", match, 1);
    chk("ident_timeout", timeout, 0);
    chk("ident_latency", ld, 8);

    m = '0; m[127] = 1; m[100] = 1; m[64] = 1; m[31] = 1; m[0] = 1;
    run_txn(a, a ^ m, 8'd4, 4, 0, 1, ls, ld);
    chk("hd5_thr4_hd", hd, 8'd5);
    chk("hd5_thr4_match", match, 0);
    run_txn(a, a ^ m, 8'd5, 2, 0, 0, ls, ld);
    chk("hd5_thr5_match", match, 1);

    run_txn(a, ~a, 8'd127, 2, 0, 0, ls, ld);
    chk("full_hd", hd, 8'h80);
    chk("full_match", match, 0);

    run_txn(a, a, 8'd200, 1000, 0, 0, ls, ld);
    chk("to_latency", ls, 18);
    chk("to_hd", hd, 8'hFF);
    chk("to_flag", timeout, 1);
    chk("to_match", match, 0);
    chk("to_puf_rst", puf_rst, 1);
    chk("to_busy", busy, 0);

    r = '0; r[5] = 1; r[50] = 1; r[120] = 1;
    run_txn(a, a ^ r, 8'd2, 6, 1, 0, ls, ld);
    chk("ignored_start_hd", hd, 8'd3);
    chk("ignored_start_match", match, 0);

    // Asynchronous reset while slice 3 is pending.
    start = 1; ref_resp = a; threshold = 8'd10; puf_out = a ^ m;
    @(negedge clk);
    start = 0; puf_done = 1;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    chk("arst_puf_rst", puf_rst, 1);
    chk("arst_hd", hd, 8'd0);
    chk("arst_match", match, 0);
    chk("arst_timeout", timeout, 0);
    puf_done = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    run_txn(a, a ^ m, 8'd5, 3, 0, 0, ls, ld);
    chk("post_rst_hd", hd, 8'd5);
    chk("post_rst_match", match, 1);

    for (int n = 0; n < 120; n++) begin
      a = rnd128();
      case ($urandom_range(0, 3))
        0: m = '0;
        1: begin
          m = '0;
          for (int j = 0; j < int'($urandom_range(1, 8)); j++) m[$urandom_range(0, 127)] = 1'b1;
        end
        2: m = rnd128();
        default: m = '1;
      endcase
      hv = $countones(m);
      if ($urandom_range(0, 3) == 0) th = 8'($urandom);
      else th = 8'(hv + int'($urandom_range(0, 4)) - 2);
      run_txn(a, a ^ m, th, $urandom_range(1, 20), 1'($urandom), 1'($urandom), ls, ld);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
